// File: rtl/sbox_share_arbiter_pkg.sv
// sbox_share_arbiter_pkg
//   Shared definitions for the S-box sharing arbiter: arbiter state
//   encoding, the substitution word width and the requester-index width
//   helper used to size grant/pointer/response-id fields.
package sbox_share_arbiter_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Index width for n requesters, never narrower than one bit so that a
  // single-bit id port still exists for the smallest configuration.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sbox_share_arbiter_rr_picker.sv
// sbox_share_arbiter_rr_picker
//   Combinational round-robin first-valid finder. Scans requesters in the
//   order rr_ptr_i, rr_ptr_i+1, ... (wrapping at NUM_REQ) and returns the
//   first one whose valid bit is set.
//
// Ports:
//   req_valid_i  in   NUM_REQ  per-requester valid
//   rr_ptr_i     in   ID_W     index the scan starts from
//   idx_o        out  ID_W     chosen requester (0 when none found)
//   found_o      out  1        at least one requester is valid
module sbox_share_arbiter_rr_picker
  import sbox_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               found_o
);

  // One extra bit so pointer+offset can exceed NUM_REQ-1 before wrapping.
  logic [ID_W:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr_i} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found_o && req_valid_i[cand[ID_W-1:0]]) begin
        idx_o   = cand[ID_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter
//   Shares one external 32-bit S-box word-substitution unit between
//   NUM_REQ requesters. Requesters win the unit round-robin for bursts of
//   1..MAX_BEATS words; the substituted word is captured in a one-entry
//   response buffer tagged with the owning requester and a last flag.
//
// Ports:
//   clk        in   1            clock, rising edge
//   reset_n    in   1            synchronous active-low reset
//   req_valid  in   NUM_REQ      per-requester word valid
//   req_word   in   32*NUM_REQ   requester i at [32*i+31:32*i]
//   req_last   in   NUM_REQ      final word of requester's burst
//   req_ready  out  NUM_REQ      per-requester accept, at most one high
//   sbox_in    out  32           word presented to the substitution unit
//   sbox_out   in   32           substituted word (combinational)
//   rsp_valid  out  1            response buffer full
//   rsp_word   out  32           substituted word
//   rsp_id     out  ID_W         owner of rsp_word
//   rsp_last   out  1            final word of burst (requester or forced)
//   rsp_ready  in   1            downstream accepts the response
//
// Optional feature, macro SBOX_SHARE_ARBITER_STATS_EN:
//   stat_beats   out  32  accepted beats, saturating
//   stat_forced  out  16  bursts cut at MAX_BEATS without req_last, saturating
module sbox_share_arbiter
  import sbox_share_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int MAX_BEATS = 4,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [WORD_W*NUM_REQ-1:0] req_word,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [WORD_W-1:0]         sbox_in,
  input  logic [WORD_W-1:0]         sbox_out,
  output logic                      rsp_valid,
  output logic [WORD_W-1:0]         rsp_word,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_last,
  input  logic                      rsp_ready
`ifdef SBOX_SHARE_ARBITER_STATS_EN
  ,
  output logic [31:0]               stat_beats,
  output logic [15:0]               stat_forced
`endif
);

  localparam int                CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]   rsp_word_q, rsp_word_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_last_q, rsp_last_d;

  logic [ID_W-1:0]     pick_idx;
  logic                pick_found;
  logic                can_accept;
  logic                beat_acc;
  logic                forced_last;
  logic                beat_last;
  logic [WORD_W-1:0]   granted_word;
  logic [ID_W-1:0]     next_ptr;

  sbox_share_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .idx_o       (pick_idx),
    .found_o     (pick_found)
  );

  // A beat can only be taken when the response buffer is empty or is
  // being drained in this same cycle.
  assign can_accept   = !rsp_valid_q || rsp_ready;
  assign granted_word = req_word[int'(grant_q)*WORD_W +: WORD_W];
  assign beat_acc     = (state_q == ST_BURST) && req_valid[grant_q] && can_accept;
  assign forced_last  = (beat_cnt_q == LAST_BEAT);
  assign beat_last    = req_last[grant_q] || forced_last;
  assign next_ptr     = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  // Next-state and output decode. The grant is held through the whole
  // burst even if the owner drops valid, so bursts never interleave.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_word_d  = rsp_word_q;
    rsp_id_d    = rsp_id_q;
    rsp_last_d  = rsp_last_q;
    req_ready   = '0;
    sbox_in     = '0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // The arbitration cycle itself never accepts a word.
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        req_ready[grant_q] = can_accept;
        sbox_in            = granted_word;
        if (beat_acc) begin
          rsp_valid_d = 1'b1;
          rsp_word_d  = sbox_out;
          rsp_id_d    = grant_q;
          rsp_last_d  = beat_last;
          if (beat_last) begin
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response buffer registers; reset also discards any
  // in-flight burst and buffered response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_word_q  <= '0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_word_q  <= rsp_word_d;
      rsp_id_q    <= rsp_id_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_word  = rsp_word_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_last  = rsp_last_q;

`ifdef SBOX_SHARE_ARBITER_STATS_EN
  logic [31:0] stat_beats_q;
  logic [15:0] stat_forced_q;

  // A termination counts as forced only when the requester did not flag
  // the word as last itself.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_beats_q  <= '0;
      stat_forced_q <= '0;
    end else begin
      if (beat_acc && (stat_beats_q != '1)) begin
        stat_beats_q <= stat_beats_q + 32'd1;
      end
      if (beat_acc && forced_last && !req_last[grant_q] && (stat_forced_q != '1)) begin
        stat_forced_q <= stat_forced_q + 16'd1;
      end
    end
  end

  assign stat_beats  = stat_beats_q;
  assign stat_forced = stat_forced_q;
`endif

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// tb_sbox_share_arbiter
//   Self-checking bench for sbox_share_arbiter with NUM_REQ=2,
//   MAX_BEATS=4. Provides a behavioural AES S-box as the external
//   substitution unit. Covers reset, directed cycle tables, contention,
//   backpressure, forced termination, reset mid-burst and a randomized run
//   against a transaction-level reference model.
//   Stat ports are connected and checked when SBOX_SHARE_ARBITER_STATS_EN
//   is defined.
module tb_sbox_share_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int MAX_BEATS = 4;
  localparam int NW        = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [63:0] req_word;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic        rsp_valid;
  logic [31:0] rsp_word;
  logic [0:0]  rsp_id;
  logic        rsp_last;
  logic        rsp_ready;
`ifdef SBOX_SHARE_ARBITER_STATS_EN
  logic [31:0] stat_beats;
  logic [15:0] stat_forced;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [7:0] sboxTab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // External substitution unit: combinational byte-wise S-box.
  assign sbox_out = {sboxTab[sbox_in[31:24]], sboxTab[sbox_in[23:16]],
                     sboxTab[sbox_in[15:8]],  sboxTab[sbox_in[7:0]]};

  function automatic logic [31:0] sboxWord(input logic [31:0] w);
    return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
  endfunction

  sbox_share_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_word  (req_word),
    .req_last  (req_last),
    .req_ready (req_ready),
    .sbox_in   (sbox_in),
    .sbox_out  (sbox_out),
    .rsp_valid (rsp_valid),
    .rsp_word  (rsp_word),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last),
    .rsp_ready (rsp_ready)
`ifdef SBOX_SHARE_ARBITER_STATS_EN
    ,
    .stat_beats  (stat_beats),
    .stat_forced (stat_forced)
`endif
  );

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let them settle.
  task automatic applyStimulus(input logic rn, input logic [1:0] v, input logic [63:0] w,
                               input logic [1:0] l, input logic r);
    @(negedge clk);
    reset_n   = rn;
    req_valid = v;
    req_word  = w;
    req_last  = l;
    rsp_ready = r;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'b00, 64'd0, 2'b00, 1'b0);
    applyStimulus(1'b1, 2'b00, 64'd0, 2'b00, 1'b0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_word",  rsp_word,       32'd0);
    checkOutput("reset_rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("reset_rsp_last",  32'(rsp_last),  32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_sbox_in",   sbox_in,        32'd0);
  endtask

  // Cycle table record: inputs plus expected outputs seen after settling.
  typedef struct {
    logic [1:0]  valid;
    logic [63:0] word;
    logic [1:0]  last;
    logic        rdy;
    logic [1:0]  expReady;
    logic        expRspValid;
    logic [31:0] expWord;
    logic        expId;
    logic        expLast;
  } vec_t;

  function automatic vec_t mkVec(input logic [1:0] v, input logic [63:0] w, input logic [1:0] l,
                                 input logic r, input logic [1:0] er, input logic ev,
                                 input logic [31:0] ew, input logic ei, input logic el);
    vec_t t;
    t.valid = v; t.word = w; t.last = l; t.rdy = r;
    t.expReady = er; t.expRspValid = ev; t.expWord = ew; t.expId = ei; t.expLast = el;
    return t;
  endfunction

  vec_t vecs [11];

  logic [31:0] streamWord [8];
  logic        streamLast [8];
  logic [31:0] gotWord [$];
  logic        gotLast [$];
  int          gotId   [$];
  int          gotCyc  [$];

  // Feed streamWord[0..n-1] from requester rq and collect every response
  // handed downstream; rsp_ready is withheld for holdLen cycles.
  task automatic runStream(input int rq, input int n, input int holdStart, input int holdLen);
    int          idx;
    logic [31:0] held;
    logic [1:0]  v;
    logic [63:0] w;
    logic [1:0]  l;
    logic        inHold;
    idx  = 0;
    held = '0;
    gotWord.delete(); gotLast.delete(); gotId.delete(); gotCyc.delete();
    for (int cyc = 0; cyc < 60 && gotWord.size() < n; cyc++) begin
      v = '0; w = '0; l = '0;
      if (idx < n) begin
        v = 2'(1 << rq);
        w = 64'(streamWord[idx]) << (32 * rq);
        l = 2'(streamLast[idx]) << rq;
      end
      inHold = (cyc >= holdStart) && (cyc < holdStart + holdLen);
      applyStimulus(1'b1, v, w, l, !inHold);
      if (inHold && rsp_valid) begin
        if (cyc == holdStart) held = rsp_word;
        else checkOutput("bp_word_stable", rsp_word, held);
        checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        gotWord.push_back(rsp_word);
        gotLast.push_back(rsp_last);
        gotId.push_back(int'(rsp_id));
        gotCyc.push_back(cyc);
      end
      if ((req_valid & req_ready & v) != 2'b00) idx++;
    end
    checkOutput("stream_count", 32'(gotWord.size()), 32'(n));
  endtask

  logic [31:0] rw [2][NW];
  logic        rl [2][NW];
  int          rIdx [2];
  int          part [2];
  int          curOwner;
  logic [33:0] expQ [$];

  initial begin
    logic [1:0]  v, acc;
    logic [63:0] w;
    logic [1:0]  l;
    logic        r;
    logic        term;
    logic [33:0] e;
    int          got;

    reset_n = 1'b0; req_valid = '0; req_word = '0; req_last = '0; rsp_ready = 1'b0;

    vecs[0]  = mkVec(2'b01, 64'h00000000_00010253, 2'b01, 1, 2'b00, 0, 32'h0, 0, 0);
    vecs[1]  = mkVec(2'b01, 64'h00000000_00010253, 2'b01, 1, 2'b01, 0, 32'h0, 0, 0);
    vecs[2]  = mkVec(2'b00, 64'h0,                 2'b00, 1, 2'b00, 1, 32'h637c77ed, 0, 1);
    vecs[3]  = mkVec(2'b00, 64'h0,                 2'b00, 1, 2'b00, 0, 32'h0, 0, 0);
    vecs[4]  = mkVec(2'b10, 64'h00000000_00000000, 2'b00, 1, 2'b00, 0, 32'h0, 0, 0);
    vecs[5]  = mkVec(2'b10, 64'h00000000_00000000, 2'b00, 1, 2'b10, 0, 32'h0, 0, 0);
    vecs[6]  = mkVec(2'b10, 64'hffffffff_00000000, 2'b00, 1, 2'b10, 1, 32'h63636363, 1, 0);
    vecs[7]  = mkVec(2'b10, 64'h53535353_00000000, 2'b00, 1, 2'b10, 1, 32'h16161616, 1, 0);
    vecs[8]  = mkVec(2'b10, 64'h01010101_00000000, 2'b10, 1, 2'b10, 1, 32'hedededed, 1, 0);
    vecs[9]  = mkVec(2'b00, 64'h0,                 2'b00, 1, 2'b00, 1, 32'h7c7c7c7c, 1, 1);
    vecs[10] = mkVec(2'b00, 64'h0,                 2'b00, 1, 2'b00, 0, 32'h0, 0, 0);

    $display("[TB] reset and directed cycle table");
    doReset();
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b1, vecs[k].valid, vecs[k].word, vecs[k].last, vecs[k].rdy);
      checkOutput($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(vecs[k].expReady));
      checkOutput($sformatf("tbl%0d_rsp_valid", k), 32'(rsp_valid), 32'(vecs[k].expRspValid));
      if (vecs[k].expRspValid) begin
        checkOutput($sformatf("tbl%0d_rsp_word", k), rsp_word, vecs[k].expWord);
        checkOutput($sformatf("tbl%0d_rsp_id", k), 32'(rsp_id), 32'(vecs[k].expId));
        checkOutput($sformatf("tbl%0d_rsp_last", k), 32'(rsp_last), 32'(vecs[k].expLast));
      end
    end

    $display("[TB] contention");
    doReset();
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      applyStimulus(1'b1, 2'b11, 64'haabbccdd_11223344, 2'b11, 1'b1);
      if (rsp_valid) begin
        checkOutput("cont_id", 32'(rsp_id), 32'(got % 2));
        checkOutput("cont_word", rsp_word,
                    sboxWord((got % 2 == 1) ? 32'haabbccdd : 32'h11223344));
        got++;
      end
    end
    checkOutput("cont_count", 32'(got), 32'd8);

    $display("[TB] backpressure");
    doReset();
    streamWord[0] = 32'h0a0b0c0d; streamLast[0] = 1'b0;
    streamWord[1] = 32'h10203040; streamLast[1] = 1'b0;
    streamWord[2] = 32'h5566aa99; streamLast[2] = 1'b0;
    streamWord[3] = 32'hdeadbeef; streamLast[3] = 1'b1;
    runStream(0, 4, 4, 3);
    for (int k = 0; k < 4 && k < gotWord.size(); k++) begin
      checkOutput("bp_word", gotWord[k], sboxWord(streamWord[k]));
      checkOutput("bp_last", 32'(gotLast[k]), (k == 3) ? 32'd1 : 32'd0);
      checkOutput("bp_id", 32'(gotId[k]), 32'd0);
    end

    $display("[TB] forced termination");
    doReset();
    for (int k = 0; k < 6; k++) begin
      streamWord[k] = 32'h01000000 * (k + 1) + 32'h00c0ffee;
      streamLast[k] = 1'b0;
    end
    runStream(0, 6, -1, 0);
    for (int k = 0; k < 6 && k < gotWord.size(); k++) begin
      checkOutput("forced_word", gotWord[k], sboxWord(streamWord[k]));
      checkOutput("forced_last", 32'(gotLast[k]), (k == 3) ? 32'd1 : 32'd0);
    end
    if (gotCyc.size() == 6) begin
      checkOutput("forced_stream_gap", 32'(gotCyc[1] - gotCyc[0]), 32'd1);
      checkOutput("forced_rearb_gap", 32'(gotCyc[4] - gotCyc[3]), 32'd2);
    end
`ifdef SBOX_SHARE_ARBITER_STATS_EN
    checkOutput("stat_forced", 32'(stat_forced), 32'd1);
    checkOutput("stat_beats", stat_beats, 32'd6);
`endif

    $display("[TB] reset mid-burst");
    doReset();
    streamWord[0] = 32'h01020304; streamLast[0] = 1'b1;
    runStream(0, 1, -1, 0);
    applyStimulus(1'b1, 2'b10, 64'h0f1e2d3c_00000000, 2'b00, 1'b1);
    checkOutput("rst_arb_ready", 32'(req_ready), 32'd0);
    applyStimulus(1'b1, 2'b10, 64'h0f1e2d3c_00000000, 2'b00, 1'b1);
    checkOutput("rst_grant1_ready", 32'(req_ready), 32'd2);
    applyStimulus(1'b1, 2'b10, 64'h4b5a6978_00000000, 2'b00, 1'b1);
    checkOutput("rst_beat0_word", rsp_word, sboxWord(32'h0f1e2d3c));
    applyStimulus(1'b0, 2'b10, 64'h11111111_00000000, 2'b00, 1'b0);
    checkOutput("rst_beat1_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rst_beat1_word", rsp_word, sboxWord(32'h4b5a6978));
    applyStimulus(1'b1, 2'b11, 64'h11111111_c0ffee00, 2'b11, 1'b1);
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_mid_rsp_word", rsp_word, 32'd0);
    applyStimulus(1'b1, 2'b11, 64'h11111111_c0ffee00, 2'b11, 1'b1);
    checkOutput("rst_scan_from0", 32'(req_ready), 32'd1);
    applyStimulus(1'b1, 2'b11, 64'h11111111_c0ffee00, 2'b11, 1'b1);
    checkOutput("rst_after_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rst_after_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_after_word", rsp_word, sboxWord(32'hc0ffee00));

    $display("[TB] randomized run");
    doReset();
    for (int i = 0; i < 2; i++) begin
      rIdx[i] = 0;
      part[i] = 0;
      for (int k = 0; k < NW; k++) begin
        rw[i][k] = $urandom();
        rl[i][k] = ($urandom_range(0, 3) == 0) || (k == NW - 1);
      end
    end
    curOwner = -1;
    expQ.delete();
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (rIdx[0] == NW && rIdx[1] == NW && expQ.size() == 0 && !rsp_valid) break;
      v = '0; w = '0; l = '0;
      for (int i = 0; i < 2; i++) begin
        if (rIdx[i] < NW) begin
          w = w | (64'(rw[i][rIdx[i]]) << (32 * i));
          l = l | (2'(rl[i][rIdx[i]]) << i);
          if ($urandom_range(0, 9) < 7) v = v | 2'(1 << i);
        end else begin
          w = w | (64'($urandom()) << (32 * i));
        end
      end
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(1'b1, v, w, l, r);
      checkOutput("rand_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("rand_spurious_rsp", 32'(expQ.size()), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("rand_rsp_word", rsp_word, e[31:0]);
          checkOutput("rand_rsp_last", 32'(rsp_last), 32'(e[32]));
          checkOutput("rand_rsp_id", 32'(rsp_id), 32'(e[33]));
        end
      end
      acc = v & req_ready;
      for (int i = 0; i < 2; i++) begin
        if (((acc >> i) & 2'b01) != 2'b00) begin
          if (curOwner >= 0) checkOutput("rand_no_interleave", 32'(i), 32'(curOwner));
          part[i]++;
          term = rl[i][rIdx[i]] || (part[i] == MAX_BEATS);
          if (term) begin
            part[i]  = 0;
            curOwner = -1;
          end else begin
            curOwner = i;
          end
          expQ.push_back({1'(i), term, sboxWord(rw[i][rIdx[i]])});
          rIdx[i]++;
        end
      end
    end
    checkOutput("rand_all_sent", 32'(rIdx[0] + rIdx[1]), 32'(2 * NW));
    checkOutput("rand_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
